// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to instruction memory, buffers the in-order
// responses with their PC in a small FIFO and hands them to the decoder on valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0]   Depth = FIFO_DEPTH[CntW:0];
  localparam logic [CntW-1:0] One   = 1;
  localparam logic [PtrW-1:0] OneP  = 1;

  logic [31:0]     pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CntW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            req_q, req_d;
  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem   [FIFO_DEPTH];
  logic            gnt, rv_ok, push, pop;
  logic [31:0]     target;
  logic            unused_redir_lsb;

  assign target           = {redirect_pc_i[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc_i[1:0];

  assign gnt   = req_q & imem_gnt_i;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rv_ok = imem_rvalid_i & (out_q != '0);
  assign pop   = instr_valid_o & instr_ready_i;
  assign push  = rv_ok & (drop_q == '0) & ~redirect_i;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    drop_d    = drop_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (gnt) pc_d = pc_q + 32'd4;

    if (gnt && !rv_ok)      out_d = out_q + One;
    else if (!gnt && rv_ok) out_d = out_q - One;

    if (rv_ok && (drop_q != '0)) drop_d = drop_q - One;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + OneP;
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + OneP;

    if (push && !pop)      cnt_d = cnt_q + One;
    else if (!push && pop) cnt_d = cnt_q - One;

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_i) begin
      pc_d      = target;
      resp_pc_d = target;
      cnt_d     = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      drop_d    = out_d;
    end

    req_d = ({1'b0, out_d} + {1'b0, cnt_d}) < Depth;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      cnt_q     <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      req_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      req_q     <= req_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted in cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (cnt_q != '0);
  assign instr_data_o  = instr_valid_o ? data_mem[rd_ptr_q] : 32'd0;
  assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model with random grant/latency, a
// scoreboard of the sequential PC stream expected since the last reset or redirect.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc   = 32'h0000_0000;
  localparam int          FifoDepth = 2;
  localparam int          NCyc      = 4000;

  logic        clk_i;
  logic        rstn_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_data_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  fetch_unit #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_data_o (instr_data_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Expected delivery stream {pc, data}, restarted on every reset/redirect.
  logic [63:0] exp_q[$];
  logic [31:0] next_exp_pc;
  // Memory model: granted addresses and the earliest cycle each may respond.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] fetch_pc;

  int unsigned gnt_tab  [8] = '{100, 100,  40,  70, 100,  60, 100,  90};
  int unsigned rdy_tab  [8] = '{100,  30, 100,  70, 100,  50,  20,  90};
  int unsigned dly_tab  [8] = '{  0,   0,   3,   2,   0,   2,   1,   1};
  int unsigned redir_tab[8] = '{  0,   0,   0,   5,  10,   5,   3,   2};
  int unsigned rst_tab  [8] = '{  0,   0,   0,   0,   0,   1,   0,   1};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[7:0], a[31:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic restart_exp(input logic [31:0] pc);
    exp_q.delete();
    next_exp_pc = pc;
  endtask

  initial begin : driver
    int unsigned ph;
    int          out_before;
    logic        granted, rst_now, hold_prev, was_reset;
    logic [31:0] prev_addr;
    rstn_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    hold_prev = 1'b0; was_reset = 1'b0; prev_addr = '0;
    fetch_pc = ResetPc;
    restart_exp(ResetPc);
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk_i);
      ph = cyc / 500;
      if (was_reset) begin
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, ResetPc);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_data", instr_data_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
      end
      if (hold_prev) begin
        check("req_hold", 32'(imem_req_o), 32'd1);
        check("addr_hold", imem_addr_o, prev_addr);
      end
      if (cyc == 110) begin
        // After 10 cycles of back-pressure the buffer is full and requests stop.
        check("full_req", 32'(imem_req_o), 32'd0);
        check("full_valid", 32'(instr_valid_o), 32'd1);
      end
      out_before = pend_addr.size();
      rst_now = (cyc < 2) || ($urandom_range(99, 0) < rst_tab[ph]);
      granted = 1'b0;
      if (rst_now) begin
        rstn_i        = 1'b0;
        imem_gnt_i    = 1'($urandom_range(1, 0));
        imem_rvalid_i = (out_before != 0);
        imem_rdata_i  = $urandom;
        redirect_i    = 1'b0;
        instr_ready_i = 1'($urandom_range(1, 0));
      end else begin
        rstn_i        = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (out_before != 0 && pend_due[0] <= cyc) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        imem_gnt_i = ($urandom_range(99, 0) < gnt_tab[ph]);
        granted    = imem_gnt_i && imem_req_o;
        if (granted) begin
          check("credit", 32'(out_before < FifoDepth), 32'd1);
          check("fetch_addr", imem_addr_o, fetch_pc);
          pend_addr.push_back(imem_addr_o);
          pend_due.push_back(cyc + 1 + int'($urandom_range(dly_tab[ph], 0)));
          fetch_pc = fetch_pc + 32'd4;
        end
        instr_ready_i = (cyc >= 100 && cyc < 110) ? 1'b0 :
                        ($urandom_range(99, 0) < rdy_tab[ph]);
        redirect_i    = ($urandom_range(99, 0) < redir_tab[ph]);
        redirect_pc_i = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                    : $urandom;
      end
      #2;
      if (!rstn_i) begin
        pend_addr.delete();
        pend_due.delete();
        fetch_pc = ResetPc;
        restart_exp(ResetPc);
      end else if (redirect_i) begin
        fetch_pc = {redirect_pc_i[31:2], 2'b00};
        restart_exp(fetch_pc);
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back({next_exp_pc, mem_word(next_exp_pc)});
        next_exp_pc = next_exp_pc + 32'd4;
      end
      hold_prev = rstn_i && !redirect_i && imem_req_o && !granted;
      prev_addr = imem_addr_o;
      was_reset = !rstn_i;
    end
    @(negedge clk_i);
    check("deliveries", 32'(delivered >= 500), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : monitor
    logic        prev_valid, prev_ready, prev_redir, prev_rstn;
    logic [31:0] prev_pc, prev_data;
    logic [63:0] e;
    int          idle;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0; prev_rstn = 1'b0;
    prev_pc = '0; prev_data = '0; idle = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (prev_rstn && prev_redir) check("valid_after_redirect", 32'(instr_valid_o), 32'd0);
      if (prev_rstn && !prev_redir && prev_valid && !prev_ready) begin
        check("head_valid_hold", 32'(instr_valid_o), 32'd1);
        check("head_pc_hold", instr_pc_o, prev_pc);
        check("head_data_hold", instr_data_o, prev_data);
      end
      if (!instr_valid_o) begin
        check("idle_pc", instr_pc_o, 32'd0);
        check("idle_data", instr_data_o, 32'd0);
      end
      if (rstn_i && instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, nothing expected", instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc_o, e[63:32]);
          check("instr_data", instr_data_o, e[31:0]);
        end
        delivered++;
        idle = 0;
      end else begin
        idle++;
        if (idle >= 200) begin
          checks++;
          errors++;
          $display("FAIL stall: got no delivery for %0d cycles, required fewer than 200", idle);
          idle = 0;
        end
      end
      prev_valid = instr_valid_o;
      prev_ready = instr_ready_i;
      prev_redir = redirect_i;
      prev_rstn  = rstn_i;
      prev_pc    = instr_pc_o;
      prev_data  = instr_data_o;
    end
  end

endmodule
